// File: rtl/arch_rf_pkg.sv
// Shared types and default sizes for the multi-port architectural register file.
package arch_rf_pkg;

    localparam int DEF_NUM_ARCH_REGS  = 32;
    localparam int DEF_REG_VAL_WIDTH  = 32;
    localparam int DEF_NUM_COMMITS    = 2;
    localparam int DEF_NUM_READ_PORTS = 2;

    typedef enum logic [1:0] {
        reg_commit_none   = 2'd0,
        reg_commit_wb     = 2'd1,
        reg_commit_store  = 2'd2,
        reg_commit_branch = 2'd3
    } commit_type_t;

    typedef enum logic [1:0] {
        DUMP_IDLE   = 2'd0,
        DUMP_STREAM = 2'd1,
        DUMP_DONE   = 2'd2
    } dump_state_t;

endpackage

// File: rtl/arch_regfile_mp_dump_fsm.sv
// Dump sequencer: walks the register index space under ready/valid and pulses done after the last beat.
module arch_rf_dump_fsm
    import arch_rf_pkg::*;
#(
    parameter int NUM_ARCH_REGS = DEF_NUM_ARCH_REGS,
    parameter int ADDR_W        = $clog2(NUM_ARCH_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dump_req,
    input  logic              dump_ready,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic              dump_done,
    output logic [ADDR_W-1:0] dump_idx
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ARCH_REGS - 1);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            DUMP_IDLE: begin
                if (dump_req) begin
                    state_d = DUMP_STREAM;
                    idx_d   = '0;
                end
            end
            DUMP_STREAM: begin
                if (dump_ready) begin
                    // Index returns to zero so idle/done never present a stale index.
                    if (idx_q == LAST_IDX) begin
                        state_d = DUMP_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            DUMP_DONE: state_d = DUMP_IDLE;
            default: begin
                state_d = DUMP_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DUMP_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign dump_busy  = (state_q != DUMP_IDLE);
    assign dump_valid = (state_q == DUMP_STREAM);
    assign dump_done  = (state_q == DUMP_DONE);
    assign dump_idx   = idx_q;

endmodule

// File: rtl/arch_regfile_mp.sv
// Multi-port architectural register file: in-order commit writes, registered reads with optional bypass, state dump.
module arch_regfile_mp
    import arch_rf_pkg::*;
#(
    parameter int NUM_ARCH_REGS  = DEF_NUM_ARCH_REGS,
    parameter int REG_VAL_WIDTH  = DEF_REG_VAL_WIDTH,
    parameter int NUM_COMMITS    = DEF_NUM_COMMITS,
    parameter int NUM_READ_PORTS = DEF_NUM_READ_PORTS,
    parameter bit BYPASS_EN      = 1'b1,
    parameter int ADDR_W         = $clog2(NUM_ARCH_REGS)
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic         [NUM_COMMITS-1:0]                commit_valid,
    input  commit_type_t                                  commit_type [NUM_COMMITS],
    input  logic         [NUM_COMMITS-1:0][ADDR_W-1:0]    commit_arch_reg_addr,
    input  logic         [NUM_COMMITS-1:0][REG_VAL_WIDTH-1:0] commit_value,
    input  logic         [NUM_READ_PORTS-1:0]             rd_en,
    input  logic         [NUM_READ_PORTS-1:0][ADDR_W-1:0] rd_addr,
    output logic         [NUM_READ_PORTS-1:0][REG_VAL_WIDTH-1:0] rd_value,
    output logic         [NUM_READ_PORTS-1:0]             rd_valid,
    input  logic                                          dump_req,
    output logic                                          dump_busy,
    output logic                                          dump_valid,
    input  logic                                          dump_ready,
    output logic         [ADDR_W-1:0]                     dump_idx,
    output logic         [REG_VAL_WIDTH-1:0]              dump_value,
    output logic                                          dump_done
);

    logic [REG_VAL_WIDTH-1:0] regs_q [NUM_ARCH_REGS];
    logic [REG_VAL_WIDTH-1:0] regs_d [NUM_ARCH_REGS];
    logic [NUM_COMMITS-1:0]   wr_en;
    logic [NUM_READ_PORTS-1:0][REG_VAL_WIDTH-1:0] rd_value_q, rd_value_d;
    logic [NUM_READ_PORTS-1:0] rd_valid_q, rd_valid_d;

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NUM_COMMITS; i++) begin
            wr_en[i] = commit_valid[i] && (commit_type[i] == reg_commit_wb) &&
                       (commit_arch_reg_addr[i] != '0);
        end
    end

    // Ascending slot order lets the youngest commit overwrite older ones to the same register.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_COMMITS; i++) begin
            if (wr_en[i]) begin
                regs_d[commit_arch_reg_addr[i]] = commit_value[i];
            end
        end
        regs_d[0] = '0;
    end

    always_comb begin
        rd_value_d = rd_value_q;
        rd_valid_d = rd_en;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            if (rd_en[p]) begin
                rd_value_d[p] = regs_q[rd_addr[p]];
                if (BYPASS_EN) begin
                    for (int i = 0; i < NUM_COMMITS; i++) begin
                        if (wr_en[i] && (commit_arch_reg_addr[i] == rd_addr[p])) begin
                            rd_value_d[p] = commit_value[i];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q     <= '{default: '0};
            rd_value_q <= '0;
            rd_valid_q <= '0;
        end else begin
            regs_q     <= regs_d;
            rd_value_q <= rd_value_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_value = rd_value_q;
    assign rd_valid = rd_valid_q;

    arch_rf_dump_fsm #(
        .NUM_ARCH_REGS (NUM_ARCH_REGS),
        .ADDR_W        (ADDR_W)
    ) u_dump_fsm (
        .clk        (clk),
        .reset      (reset),
        .dump_req   (dump_req),
        .dump_ready (dump_ready),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_done  (dump_done),
        .dump_idx   (dump_idx)
    );

    // Dump beats see the live array, so commits landing mid-dump reach beats not yet sent.
    assign dump_value = dump_valid ? regs_q[dump_idx] : '0;

endmodule

// File: doc/arch_regfile_mp.md
Name: arch_regfile_mp

Overview:
Parametrised multi-port architectural register file. It takes up to NUM_COMMITS in-order commit writes per cycle from the ROB commit stage and serves NUM_READ_PORTS registered read ports. It adds an optional commit-to-read bypass and a ready/valid dump engine that streams the whole architectural state out, for checkpoint and debug. It sits behind the commit stage and replaces the single-read-port architectural regfile plus its output flops.

Parameters:
NUM_ARCH_REGS, 32, number of architectural registers; index 0 is hardwired zero
REG_VAL_WIDTH, 32, register value width
NUM_COMMITS, 2, commit write ports; higher index = younger instruction
NUM_READ_PORTS, 2, independent read ports
BYPASS_EN, 1, 1: a same-cycle commit is visible to a read issued that cycle; 0: a read returns the pre-commit value
ADDR_W, $clog2(NUM_ARCH_REGS), derived address width; not overridden

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
commit_valid  in  NUM_COMMITS  per-slot commit valid
commit_type  in  NUM_COMMITS x commit_type_t  per-slot commit kind; only reg_commit_wb writes
commit_arch_reg_addr  in  NUM_COMMITS x ADDR_W  destination register
commit_value  in  NUM_COMMITS x REG_VAL_WIDTH  write data
rd_en  in  NUM_READ_PORTS  read request
rd_addr  in  NUM_READ_PORTS x ADDR_W  read address
rd_value  out  NUM_READ_PORTS x REG_VAL_WIDTH  registered read data
rd_valid  out  NUM_READ_PORTS  rd_en delayed one cycle
dump_req  in  1  start full-state dump; single-cycle pulse, level also accepted
dump_busy  out  1  dump engine not IDLE
dump_valid  out  1  dump beat valid
dump_ready  in  1  consumer accepts beat
dump_idx  out  ADDR_W  register index of current beat
dump_value  out  REG_VAL_WIDTH  register value of current beat
dump_done  out  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset: all registers 0. rd_value, rd_valid, dump_valid, dump_busy, dump_done, dump_idx and dump_value are 0. Dump FSM goes to IDLE. Reset mid-dump aborts the dump with no dump_done.
- Write enable per slot = commit_valid[i] & (commit_type[i]==reg_commit_wb) & (addr!=0). Writes take effect at the clock edge.
- Same register written by several slots in one cycle: highest slot index wins.
- Register 0 always reads 0; writes to it are dropped.
- Read latency is exactly 1 cycle. On edge N, rd_value[p] captures the contents at rd_addr[p] and rd_valid[p] <= rd_en[p].
- When rd_en[p]=0, rd_value[p] holds its previous value.
- BYPASS_EN=1: on a match with a same-cycle enabled commit, the youngest matching commit_value is captured instead of the array value.
- BYPASS_EN=0: the array value before the edge is captured.
- All read ports are independent. Reads to the same address in the same cycle return identical data.
- Dump FSM states: IDLE, STREAM, DONE.
  - IDLE: on dump_req, go to STREAM with dump_idx=0.
  - STREAM: dump_valid=1 and dump_value=array[dump_idx]. This is the live contents without bypass, so commits during a dump are visible to beats not yet accepted.
  - STREAM, beat transfer on dump_valid&dump_ready: dump_idx increments.
  - STREAM, transfer at dump_idx==NUM_ARCH_REGS-1: go to DONE.
  - STREAM, dump_ready=0: dump_idx and dump_valid hold.
  - DONE: dump_done=1 for one cycle, then IDLE.
- dump_req while busy is ignored; a new dump needs a fresh request in IDLE.
- Beat 0 always carries value 0.
- Dump and reads never stall each other. There is no backpressure on commit or read.

Decomposition:
- Shared package arch_rf_pkg holds:
  - commit_type_t enum, including reg_commit_wb
  - dump_state_t enum (IDLE/STREAM/DONE)
  - default width constants
- The top module holds the register array, write-priority logic and read/bypass muxing.
- One sub-module, arch_rf_dump_fsm, holds the dump FSM and index counter. It drives dump_idx and the handshake outputs; the top supplies dump_value by indexing the array.

Test Plan:
- Reset then read x5 on port 0: rd_valid=0 during reset; 1 cycle after rd_en, rd_valid=1 and rd_value=0.
- Slot0 writes x3=0xAAAA, slot1 writes x3=0xBBBB in the same cycle, then read x3 -> 0xBBBB.
- BYPASS_EN=1: commit x7=0x1234 and read x7 in the same cycle -> next cycle rd_value=0x1234. With BYPASS_EN=0 the same stimulus returns the old value 0.
- Commit x0=0xFFFF, then read x0 on both ports -> both return 0. A commit with commit_type other than reg_commit_wb to x4 leaves x4 unchanged.
- Preload xi=i+0x100 and pulse dump_req, dump_ready=1 -> 32 beats, idx 0..31, values 0 then 0x101..0x11F, followed by a 1-cycle dump_done. dump_busy is high from the cycle after dump_req until the dump_done cycle.
- Dump with dump_ready toggled every other cycle, a commit to x10=0xDEAD before beat 10, and reset asserted at beat 20:
  - dump_idx and dump_value hold while dump_ready=0.
  - Beat 10 carries 0xDEAD.
  - After reset: FSM is IDLE, dump_done is never pulsed, and all registers are 0.
